timer_ctrl: RTL

Register-programmed controller for the 8-bit timer datapath. It holds the control, reload and status registers and sequences the counter through idle, load and run states. A clock prescaler paces counting up or down, and overflow and underflow events are captured as sticky, write-1-to-clear flags with auto-reload. It sits between the peripheral bus and the counter and flag logic, and drives the timer interrupt.

---
 rtl/timer_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/timer_ctrl.sv
// timer_ctrl: bus-programmed 8-bit timer controller with prescaler, auto-reload and W1C flags.
// Define TMR_IRQ_EN to store TCR[3:2] interrupt enables and drive a registered irq.
module timer_ctrl #(
    parameter int PS_W = 4
) (
    input  logic       clk,
    input  logic       of_con_rst_n,
    input  logic       sel,
    input  logic       wr,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic [7:0] cnt,
    output logic       of,
    output logic       uf,
    output logic       irq
);
`ifdef TMR_IRQ_EN
    localparam logic [7:0] TCR_WMASK = 8'hBF;
`else
    localparam logic [7:0] TCR_WMASK = 8'hB3;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t          state_q, state_d;
    logic [7:0]      tdr_q, tdr_d, tcr_q, tcr_d, cnt_q, cnt_d;
    logic            of_q, of_d, uf_q, uf_d, of_set, uf_set;
    logic [PS_W-1:0] ps_q, ps_d, ps_mask;
    logic            wr_tdr, wr_tcr, wr_tsr, do_load, tick;

    assign wr_tdr  = sel & wr & (addr == 2'd0);
    assign wr_tcr  = sel & wr & (addr == 2'd1);
    assign wr_tsr  = sel & wr & (addr == 2'd2);
    // Load actions fire on the edge that enters LOAD, so cnt holds TDR while in LOAD.
    assign do_load = tcr_q[7] & (state_q != LOAD);
    assign ps_mask = PS_W'({tcr_q[1:0] == 2'd3, tcr_q[1], tcr_q[1:0] != 2'd0, 1'b1});
    assign tick    = (state_q == RUN) & ((ps_q & ps_mask) == ps_mask);

    always_comb begin
        state_d = state_q;
        ps_d    = ps_q;
        cnt_d   = cnt_q;
        of_set  = 1'b0;
        uf_set  = 1'b0;
        unique case (state_q)
            IDLE: begin
                ps_d    = '0;
                state_d = tcr_q[7] ? LOAD : tcr_q[4] ? RUN : IDLE;
            end
            LOAD: begin
                ps_d    = '0;
                state_d = tcr_q[4] ? RUN : IDLE;
            end
            RUN: begin
                if (tcr_q[7]) begin
                    state_d = LOAD;
                end else if (!tcr_q[4]) begin
                    state_d = IDLE;
                end else begin
                    ps_d = tick ? '0 : ps_q + PS_W'(1);
                    if (tick && !tcr_q[5]) begin
                        cnt_d  = (cnt_q == 8'hFF) ? tdr_q : cnt_q + 8'd1;
                        of_set = (cnt_q == 8'hFF);
                    end else if (tick) begin
                        cnt_d  = (cnt_q == 8'h00) ? tdr_q : cnt_q - 8'd1;
                        uf_set = (cnt_q == 8'h00);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (do_load) begin
            cnt_d = tdr_q;
            ps_d  = '0;
        end
    end

    assign tdr_d = wr_tdr ? wdata : tdr_q;
    assign tcr_d = wr_tcr ? (wdata & TCR_WMASK) : do_load ? {1'b0, tcr_q[6:0]} : tcr_q;
    // A flag event on the same edge as its W1C clear keeps the flag set.
    assign of_d  = of_set | (of_q & ~(wr_tsr & wdata[0]));
    assign uf_d  = uf_set | (uf_q & ~(wr_tsr & wdata[1]));

    always_ff @(posedge clk or negedge of_con_rst_n) begin
        if (!of_con_rst_n) begin
            state_q <= IDLE;
            tdr_q   <= 8'h00;
            tcr_q   <= 8'h00;
            cnt_q   <= 8'h00;
            of_q    <= 1'b0;
            uf_q    <= 1'b0;
            ps_q    <= '0;
        end else begin
            state_q <= state_d;
            tdr_q   <= tdr_d;
            tcr_q   <= tcr_d;
            cnt_q   <= cnt_d;
            of_q    <= of_d;
            uf_q    <= uf_d;
            ps_q    <= ps_d;
        end
    end

`ifdef TMR_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge of_con_rst_n) begin
        if (!of_con_rst_n) irq_q <= 1'b0;
        else irq_q <= (of_q & tcr_q[2]) | (uf_q & tcr_q[3]);
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign rdata = (addr == 2'd0) ? tdr_q :
                   (addr == 2'd1) ? tcr_q :
                   (addr == 2'd2) ? {6'b0, uf_q, of_q} : cnt_q;
    assign cnt   = cnt_q;
    assign of    = of_q;
    assign uf    = uf_q;

endmodule
